// File: rtl/vector_mem_responder.sv
// Memory-stage responder: accepts one scalar or vector load/store per transaction and
// serializes it one lane per cycle over an internal single-port RAM.
module vector_mem_responder #(
  parameter int unsigned registerSize = 8,
  parameter int unsigned vectorSize   = 4,
  parameter int unsigned addrWidth    = 16,
  parameter int unsigned memDepth     = 256
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_write,
  input  logic                               req_scalar,
  input  logic [addrWidth-1:0]               req_addr,
  input  logic [vectorSize*registerSize-1:0] req_wdata,
  output logic                               resp_valid,
  output logic [vectorSize*registerSize-1:0] resp_rdata,
  output logic                               resp_err,
  output logic                               busy
);

  localparam int unsigned CntW = (vectorSize > 1) ? $clog2(vectorSize) : 1;
  localparam int unsigned IdxW = (memDepth > 1) ? $clog2(memDepth) : 1;
  localparam logic [CntW-1:0]    LastVec = CntW'(vectorSize - 1);
  localparam logic [addrWidth:0] DepthW  = (addrWidth + 1)'(memDepth);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                                   state_q;
  logic   [CntW-1:0]                        cnt_q;
  logic   [addrWidth-1:0]                   addr_q;
  logic                                     write_q;
  logic                                     scalar_q;
  logic   [vectorSize-1:0][registerSize-1:0] wdata_q;
  logic   [vectorSize-1:0][registerSize-1:0] rbuf_q;
  logic                                     err_q;
  logic                                     ready_q;

  logic [registerSize-1:0] mem [memDepth];

  logic [addrWidth:0] lane_addr;
  logic               in_range;
  logic [IdxW-1:0]    lane_idx;
  logic [CntW-1:0]    last_lane;

  // Lane address is one bit wider than the request address so it never wraps.
  assign lane_addr = {1'b0, addr_q} + (addrWidth + 1)'(cnt_q);
  assign in_range  = lane_addr < DepthW;
  assign lane_idx  = lane_addr[IdxW-1:0];
  assign last_lane = scalar_q ? '0 : LastVec;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rbuf_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (req_valid && ready_q) begin
            addr_q   <= req_addr;
            write_q  <= req_write;
            scalar_q <= req_scalar;
            wdata_q  <= req_wdata;
            rbuf_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            state_q  <= StAccess;
          end
        end
        StAccess: begin
          if (!in_range) begin
            err_q <= 1'b1;
          end else if (!write_q) begin
            rbuf_q[cnt_q] <= mem[lane_idx];
          end
          if (cnt_q == last_lane) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Writes are gated by reset so an aborted store stops at the lane in flight.
  always_ff @(posedge clk) begin
    if (rst && (state_q == StAccess) && write_q && in_range) begin
      mem[lane_idx] <= wdata_q[cnt_q];
    end
  end

  assign req_ready  = ready_q;
  assign busy       = (state_q != StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = resp_valid ? rbuf_q : '0;
  assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_vector_mem_responder.sv
// Directed bench for vector_mem_responder: scoreboard of expected responses checked
// against a byte-array memory model.
module tb_vector_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_scalar;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl [256];

  vector_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_scalar(req_scalar),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: lanes beyond depth flag an error, never wrap, read as zero.
  task automatic model_txn(input logic w, input logic s, input logic [15:0] a,
                           input logic [31:0] d, output logic [31:0] er, output logic ee);
    logic [16:0] la;
    er = '0;
    ee = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!(s && i > 0)) begin
        la = {1'b0, a} + 17'(i);
        if (la > 17'd255) ee = 1'b1;
        else if (w) mdl[la[7:0]] = d[i*8 +: 8];
        else er[i*8 +: 8] = mdl[la[7:0]];
      end
    end
  endtask

  task automatic push_txn(input logic w, input logic s, input logic [15:0] a,
                          input logic [31:0] d);
    exp_t e;
    model_txn(w, s, a, d, e.rdata, e.err);
    e.lat = s ? 2 : 5;
    sb.push_back(e);
    req_write  = w;
    req_scalar = s;
    req_addr   = a;
    req_wdata  = d;
    req_valid  = 1'b1;
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic wait_accept(output int waits);
    waits = 0;
    while (!req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check("accept_ready", req_ready, 1);
    @(posedge clk);
  endtask

  // Counts cycles from the accept edge, compares against the scoreboard head, then
  // checks the idle cycle that follows the response.
  task automatic wait_resp(input string tag);
    int   n = 0;
    exp_t e;
    do begin
      @(negedge clk);
      n++;
      if (!resp_valid) check({tag, "_busy_access"}, busy, 1);
    end while (!resp_valid && n < 20);
    check({tag, "_resp_valid"}, resp_valid, 1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_latency"}, n, e.lat);
      check({tag, "_rdata"}, resp_rdata, e.rdata);
      check({tag, "_err"}, resp_err, e.err);
      check({tag, "_busy_resp"}, busy, 1);
    end
    @(negedge clk);
    check({tag, "_post_valid"}, resp_valid, 0);
    check({tag, "_post_rdata"}, resp_rdata, 0);
    check({tag, "_post_busy"}, busy, 0);
    check({tag, "_post_ready"}, req_ready, 1);
  endtask

  task automatic do_txn(input logic w, input logic s, input logic [15:0] a,
                        input logic [31:0] d, input string tag);
    int wt;
    push_txn(w, s, a, d);
    wait_accept(wt);
    #1 req_valid = 1'b0;
    wait_resp(tag);
  endtask

  initial begin
    int wt;
    rst        = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_scalar = 1'b0;
    req_addr   = 16'h0040;
    req_wdata  = 32'hFFFF_FFFF;

    // Reset holds everything quiet even with a request pending.
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_resp_rdata", resp_rdata, 0);
    end
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    check("release_ready", req_ready, 1);
    check("release_busy", busy, 0);

    do_txn(1'b1, 1'b0, 16'h0010, 32'h4433_2211, "vst10");
    do_txn(1'b0, 1'b0, 16'h0010, 32'h0, "vld10");

    do_txn(1'b1, 1'b0, 16'h0020, 32'h8877_6655, "vst20");
    do_txn(1'b1, 1'b1, 16'h0020, 32'hFFFF_FFA5, "sst20");
    do_txn(1'b0, 1'b1, 16'h0020, 32'h0, "sld20");
    do_txn(1'b0, 1'b0, 16'h0020, 32'h0, "vld20");

    do_txn(1'b1, 1'b0, 16'h0000, 32'h0D0C_0B0A, "vst0");
    do_txn(1'b1, 1'b0, 16'd254, 32'h0403_0201, "vst254");
    do_txn(1'b0, 1'b0, 16'd254, 32'h0, "vld254");
    do_txn(1'b0, 1'b0, 16'hFFFF, 32'h0, "vldffff");
    do_txn(1'b0, 1'b0, 16'h0000, 32'h0, "vld0");

    // req_valid held high: second request changes inputs mid-flight and waits its turn.
    push_txn(1'b1, 1'b0, 16'h0050, 32'h1312_1110);
    wait_accept(wt);
    #1 push_txn(1'b0, 1'b0, 16'h0050, 32'hDEAD_BEEF);
    wait_resp("hsA");
    wait_accept(wt);
    check("hs_second_wait", wt, 0);
    #1 req_valid = 1'b0;
    wait_resp("hsB");

    // Reset after two store lanes have committed: only lanes 0..1 change.
    do_txn(1'b1, 1'b0, 16'h0030, 32'h9C9B_9A99, "vst30pre");
    req_write  = 1'b1;
    req_scalar = 1'b0;
    req_addr   = 16'h0030;
    req_wdata  = 32'hDDCC_BBAA;
    req_valid  = 1'b1;
    mdl[8'h30] = 8'hAA;
    mdl[8'h31] = 8'hBB;
    wait_accept(wt);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      check("abort_resp_valid", resp_valid, 0);
      check("abort_busy", busy, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_release_ready", req_ready, 1);
    do_txn(1'b0, 1'b0, 16'h0030, 32'h0, "vld30");
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
